ypbpr_sync_insert: RTL and testbench

// Downstream stage of the RGB->YPbPr converter. Takes Y/Pb/Pr on the green/blue/red lanes plus delayed

---
 rtl/ypbpr_sync_insert.sv | 194 +++++++++++++++++++
 tb/tb_ypbpr_sync_insert.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ypbpr_sync_insert.sv
// Component-video output stage: Y gain/offset, blanking levels and sync-on-green insertion,
// with a run-length composite-sync polarity detector and lock state machine.
module ypbpr_sync_insert #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned BLACK_LVL   = 16,
  parameter int unsigned SYNC_LVL    = 0,
  parameter int unsigned Y_GAIN      = 220,
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter bit          DEFAULT_POL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ena,
  input  logic             pixel_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] pb_in,
  input  logic [WIDTH-1:0] pr_in,
  input  logic             cs_in,
  input  logic             hb_in,
  input  logic             vb_in,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] pb_out,
  output logic [WIDTH-1:0] pr_out,
  output logic             sync_out,
  output logic             locked,
  output logic             polarity
);

  localparam logic [WIDTH-1:0] MID   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] BLACK = WIDTH'(BLACK_LVL);
  localparam logic [WIDTH-1:0] SYNCV = WIDTH'(SYNC_LVL);
  localparam logic [7:0]       GAIN  = 8'(Y_GAIN);
  localparam int unsigned      MW    = $clog2(LOCK_COUNT + 1);
  localparam logic [MW-1:0]    LOCK_N = MW'(LOCK_COUNT);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  // ---------------- stage 1: input registers and gain multiply ----------------
  logic             ena1_q, hb1_q, vb1_q, cs1_q, sync1_q;
  logic [WIDTH-1:0] y1_q, pb1_q, pr1_q, scaled1_q;
  logic [WIDTH+7:0] prod_d;
  logic [WIDTH-1:0] scaled_d;
  logic             pol_q;

  always_comb begin
    prod_d   = (WIDTH+8)'(y_in) * (WIDTH+8)'(GAIN);
    scaled_d = WIDTH'(prod_d >> 8);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ena1_q    <= 1'b0;
      hb1_q     <= 1'b0;
      vb1_q     <= 1'b0;
      cs1_q     <= 1'b0;
      sync1_q   <= 1'b0;
      y1_q      <= '0;
      pb1_q     <= MID;
      pr1_q     <= MID;
      scaled1_q <= '0;
    end else begin
      ena1_q    <= ena;
      hb1_q     <= hb_in;
      vb1_q     <= vb_in;
      cs1_q     <= cs_in;
      sync1_q   <= cs_in ^ ~pol_q;
      y1_q      <= y_in;
      pb1_q     <= pb_in;
      pr1_q     <= pr_in;
      scaled1_q <= scaled_d;
    end
  end

  // ---------------- stage 2: output select ----------------
  logic [WIDTH:0]   ysum;
  logic [WIDTH-1:0] y_d, pb_d, pr_d, y_q, pb_q, pr_q;
  logic             sync_d, sync_q;

  always_comb begin
    ysum   = {1'b0, scaled1_q} + {1'b0, BLACK};
    y_d    = ysum[WIDTH] ? '1 : ysum[WIDTH-1:0];
    pb_d   = pb1_q;
    pr_d   = pr1_q;
    sync_d = 1'b0;
    if (!ena1_q) begin
      y_d    = y1_q;
      sync_d = cs1_q;
    end else if (sync1_q) begin
      y_d    = SYNCV;
      pb_d   = MID;
      pr_d   = MID;
      sync_d = 1'b1;
    end else if (hb1_q || vb1_q) begin
      y_d  = BLACK;
      pb_d = MID;
      pr_d = MID;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_q    <= BLACK;
      pb_q   <= MID;
      pr_q   <= MID;
      sync_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      pb_q   <= pb_d;
      pr_q   <= pr_d;
      sync_q <= sync_d;
    end
  end

  // ---------------- polarity detector ----------------
  // The edge compares live cs_in against its registered copy, so the decision uses the
  // counts of the completed period and the edge pixel itself opens the new one.
  logic [CNT_W-1:0] hi_q, lo_q;
  logic             rise, valid, dec, sat;

  always_comb begin
    rise  = cs_in & ~cs1_q;
    valid = rise & (|hi_q) & (|lo_q);
    dec   = hi_q < lo_q;
    sat   = (&hi_q) | (&lo_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (rise) begin
      hi_q <= CNT_W'(pixel_in & cs_in);
      lo_q <= CNT_W'(pixel_in & ~cs_in);
    end else if (pixel_in) begin
      if (cs_in && !(&hi_q))  hi_q <= hi_q + 1'b1;
      if (!cs_in && !(&lo_q)) lo_q <= lo_q + 1'b1;
    end
  end

  // ---------------- lock state machine ----------------
  state_t        state_q;
  logic [MW-1:0] match_q, match_nxt;
  logic          prev_dec_q, locked_q, same;

  always_comb begin
    same      = (match_q != '0) && (dec == prev_dec_q);
    match_nxt = !same ? MW'(1) : ((match_q == LOCK_N) ? match_q : match_q + 1'b1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= UNLOCKED;
      match_q    <= '0;
      prev_dec_q <= 1'b0;
      pol_q      <= DEFAULT_POL;
      locked_q   <= 1'b0;
    end else if (sat) begin
      state_q  <= UNLOCKED;
      match_q  <= '0;
      pol_q    <= DEFAULT_POL;
      locked_q <= 1'b0;
    end else if (valid) begin
      prev_dec_q <= dec;
      unique case (state_q)
        UNLOCKED: begin
          match_q <= match_nxt;
          if (match_nxt == LOCK_N) begin
            state_q  <= LOCKED;
            pol_q    <= dec;
            locked_q <= 1'b1;
          end
        end
        LOCKED: begin
          if (dec != prev_dec_q) begin
            state_q  <= UNLOCKED;
            match_q  <= MW'(1);
            pol_q    <= DEFAULT_POL;
            locked_q <= 1'b0;
          end
        end
        default: state_q <= UNLOCKED;
      endcase
    end
  end

  assign y_out    = y_q;
  assign pb_out   = pb_q;
  assign pr_out   = pr_q;
  assign sync_out = sync_q;
  assign locked   = locked_q;
  assign polarity = pol_q;

endmodule

// File: tb/tb_ypbpr_sync_insert.sv
// Directed bench for ypbpr_sync_insert: scaling, blanking, polarity lock/relock, timeout,
// passthrough and asynchronous reset.
module tb_ypbpr_sync_insert;

  logic       clk = 1'b0;
  logic       reset_n, ena, pixel_in, cs_in, hb_in, vb_in;
  logic [7:0] y_in, pb_in, pr_in, y_out, pb_out, pr_out;
  logic       sync_out, locked, polarity;
  int         passed = 0;
  int         total  = 0;

  always #5 clk = ~clk;

  ypbpr_sync_insert #(.WIDTH(8), .BLACK_LVL(16), .SYNC_LVL(0), .Y_GAIN(220), .CNT_W(12),
                      .LOCK_COUNT(4), .DEFAULT_POL(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .pixel_in(pixel_in),
    .y_in(y_in), .pb_in(pb_in), .pr_in(pr_in), .cs_in(cs_in), .hb_in(hb_in), .vb_in(vb_in),
    .y_out(y_out), .pb_out(pb_out), .pr_out(pr_out), .sync_out(sync_out),
    .locked(locked), .polarity(polarity)
  );

  task automatic run(input logic cs, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cs_in = cs;
    end
  endtask

  // low run of n_low pixels, then the rising edge pixel; returns after that edge is clocked
  task automatic rise_after(input int n_low);
    run(1'b0, n_low);
    run(1'b1, 1);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; ena = 1'b1; pixel_in = 1'b1; cs_in = 1'b1;
    hb_in = 1'b0; vb_in = 1'b0; y_in = 8'd0; pb_in = 8'd0; pr_in = 8'd0;
    #12;
    total++;
    if ({y_out, pb_out, pr_out, sync_out, locked, polarity} !== {8'd16, 8'd128, 8'd128, 3'b000})
      $display("FAIL reset_outputs: got %h expected %h",
               {y_out, pb_out, pr_out, sync_out, locked, polarity}, {8'd16, 8'd128, 8'd128, 3'b000});
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_scale;
    logic [7:0]  vy [3] = '{8'd255, 8'd0, 8'd128};
    logic [7:0]  vb [3] = '{8'd40, 8'd90, 8'd128};
    logic [7:0]  vr [3] = '{8'd210, 8'd60, 8'd128};
    logic [7:0]  ey [3] = '{8'd235, 8'd16, 8'd126};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        total++;
        if ({y_out, pb_out, pr_out} !== {ey[i-2], vb[i-2], vr[i-2]})
          $display("FAIL scale_%0d: got %h expected %h", i - 2,
                   {y_out, pb_out, pr_out}, {ey[i-2], vb[i-2], vr[i-2]});
        else passed++;
      end
      if (i < 3) begin
        y_in = vy[i]; pb_in = vb[i]; pr_in = vr[i];
      end
    end
  endtask

  task automatic test_blank;
    y_in = 8'd100; pb_in = 8'd200; pr_in = 8'd30; hb_in = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({y_out, pb_out, pr_out, sync_out} !== {8'd16, 8'd128, 8'd128, 1'b0})
      $display("FAIL hblank: got %h expected %h", {y_out, pb_out, pr_out, sync_out},
               {8'd16, 8'd128, 8'd128, 1'b0});
    else passed++;
    hb_in = 1'b0; vb_in = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({y_out, pb_out, pr_out, sync_out} !== {8'd16, 8'd128, 8'd128, 1'b0})
      $display("FAIL vblank: got %h expected %h", {y_out, pb_out, pr_out, sync_out},
               {8'd16, 8'd128, 8'd128, 1'b0});
    else passed++;
    vb_in = 1'b0;
  endtask

  task automatic test_lock_low;
    y_in = 8'd128; pb_in = 8'd200; pr_in = 8'd30;
    run(1'b1, 300);
    for (int i = 1; i <= 4; i++) begin
      rise_after(20);
      if (i == 3) begin
        total++;
        if (locked !== 1'b0) $display("FAIL lock_low_early: got %b expected 0", locked);
        else passed++;
      end
      if (i == 4) begin
        total++;
        if ({locked, polarity} !== 2'b10)
          $display("FAIL lock_low: got lock/pol %b expected 10", {locked, polarity});
        else passed++;
      end
      run(1'b1, 299);
    end
    run(1'b0, 5);
    total++;
    if ({y_out, pb_out, sync_out} !== {8'd0, 8'd128, 1'b1})
      $display("FAIL sync_low_run: got %h expected %h", {y_out, pb_out, sync_out},
               {8'd0, 8'd128, 1'b1});
    else passed++;
    run(1'b0, 15);
    run(1'b1, 300);
  endtask

  task automatic test_relock_high;
    rise_after(100);
    total++;
    if (locked !== 1'b1) $display("FAIL hold_lock: got %b expected 1", locked);
    else passed++;
    run(1'b1, 19);
    rise_after(300);
    total++;
    if ({locked, polarity} !== 2'b00)
      $display("FAIL unlock_on_flip: got lock/pol %b expected 00", {locked, polarity});
    else passed++;
    for (int i = 0; i < 3; i++) begin
      run(1'b1, 19);
      rise_after(300);
      total++;
      if (i < 2 && locked !== 1'b0) $display("FAIL relock_early_%0d: got %b expected 0", i, locked);
      else if (i == 2 && {locked, polarity} !== 2'b11)
        $display("FAIL relock_high: got lock/pol %b expected 11", {locked, polarity});
      else passed++;
    end
    run(1'b1, 4);
    total++;
    if ({y_out, sync_out} !== {8'd0, 1'b1})
      $display("FAIL sync_high_run: got %h expected %h", {y_out, sync_out}, {8'd0, 1'b1});
    else passed++;
    run(1'b1, 15);
  endtask

  task automatic test_timeout_passthrough;
    logic [7:0] py [6] = '{8'd255, 8'd0, 8'd77, 8'd128, 8'd1, 8'd200};
    logic [7:0] pb [6] = '{8'd1, 8'd255, 8'd128, 8'd30, 8'd99, 8'd0};
    logic [7:0] pr [6] = '{8'd2, 8'd3, 8'd250, 8'd128, 8'd64, 8'd17};
    logic       pc [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       ph [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    run(1'b0, 4000);
    @(negedge clk);
    total++;
    if (locked !== 1'b1) $display("FAIL before_timeout: got %b expected 1", locked);
    else passed++;
    run(1'b0, 100);
    total++;
    if ({locked, polarity} !== 2'b00)
      $display("FAIL timeout: got lock/pol %b expected 00", {locked, polarity});
    else passed++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        total++;
        if ({y_out, pb_out, pr_out, sync_out} !== {py[i-2], pb[i-2], pr[i-2], pc[i-2]})
          $display("FAIL passthru_%0d: got %h expected %h", i - 2,
                   {y_out, pb_out, pr_out, sync_out}, {py[i-2], pb[i-2], pr[i-2], pc[i-2]});
        else passed++;
      end
      if (i < 6) begin
        ena = 1'b0; y_in = py[i]; pb_in = pb[i]; pr_in = pr[i]; cs_in = pc[i]; hb_in = ph[i];
      end
    end
    ena = 1'b1; hb_in = 1'b0;
  endtask

  task automatic test_async_reset;
    y_in = 8'd128; pb_in = 8'd200; pr_in = 8'd50;
    run(1'b1, 300);
    for (int i = 0; i < 6; i++) begin
      rise_after(20);
      run(1'b1, 299);
    end
    total++;
    if ({locked, polarity, y_out, pb_out} !== {2'b10, 8'd126, 8'd200})
      $display("FAIL prereset: got %h expected %h", {locked, polarity, y_out, pb_out},
               {2'b10, 8'd126, 8'd200});
    else passed++;
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({y_out, pb_out, pr_out, sync_out, locked, polarity} !== {8'd16, 8'd128, 8'd128, 3'b000})
      $display("FAIL async_reset: got %h expected %h",
               {y_out, pb_out, pr_out, sync_out, locked, polarity}, {8'd16, 8'd128, 8'd128, 3'b000});
    else passed++;
    @(negedge clk);
    reset_n = 1'b1;
    run(1'b1, 300);
    for (int i = 1; i <= 4; i++) begin
      rise_after(20);
      if (i >= 3) begin
        total++;
        if (locked !== (i == 4))
          $display("FAIL relock_after_reset_%0d: got %b expected %b", i, locked, (i == 4));
        else passed++;
      end
      run(1'b1, 299);
    end
  endtask

  initial begin
    test_reset;
    test_scale;
    test_blank;
    test_lock_low;
    test_relock_high;
    test_timeout_passthrough;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
